// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: packs RV32I instruction fields into 32-bit words and writes them
// sequentially into instruction memory starting at BASE_ADDR.
// Optional feature macro: IMM_RANGE_CHECK_EN (reject immediates that do not fit the format).
module instr_encoder_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_fmt,
    input  logic [6:0]                   in_opcode,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [2:0]                   in_funct3,
    input  logic [6:0]                   in_funct7,
    input  logic [31:0]                  in_imm,
    output logic                         imem_we,
    output logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic            we_q, err_q;
    logic [31:0]     addr_q, wdata_q;
    logic [31:0]     enc_word;
    logic            fmt_ok, imm_ok;
    logic            hs, wr, bad;

    // Field packing per instruction format; formats 6/7 are flagged illegal.
    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be representable exactly in the format's encoded bits.
    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            3'd1, 3'd2: imm_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            3'd3:       imm_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            3'd4:       imm_ok = ~(|in_imm[11:0]);
            3'd5:       imm_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
            default:    imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign hs  = in_valid & in_ready;
    assign wr  = hs & fmt_ok & imm_ok;
    assign bad = hs & ~(fmt_ok & imm_ok);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state: start always (re)enters RUN; the DEPTH-th write moves to FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun: begin
                if (start)                                 state_d = StRun;
                else if (wr && count_q == CW'(DEPTH - 1))  state_d = StFull;
            end
            StFull: if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: start suppresses the handshake so it always wins over in_valid.
    always_comb begin
        in_ready = (state_q == StRun) && !full && !start;
    end

    // Registered write port, word counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            we_q  <= wr;
            err_q <= bad;
            if (wr) begin
                addr_q  <= BASE_ADDR + (32'(count_q) << 2);
                wdata_q <= enc_word;
            end
            if (start)   count_q <= '0;
            else if (wr) count_q <= count_q + CW'(1);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Self-checking bench for instr_encoder_writer (DEPTH=4) against a behavioural model.
module tb_instr_encoder_writer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        imem_we, full, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    bit          m_run;
    int          m_count;
    logic        m_we, m_err;
    logic [31:0] m_addr, m_wdata;

    instr_encoder_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from shifted and masked fields.
    function automatic logic [31:0] enc(input int unsigned fmt, opc, rd, rs1, rs2, f3, f7,
                                        input logic [31:0] imm);
        logic [31:0] b;
        b = (f3 << 12) | opc;
        case (fmt)
            0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | b;
            1: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | b;
            2: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15)
                      | ((imm & 32'h1f) << 7) | b;
            3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | b;
            4: return (imm & 32'hffff_f000) | (rd << 7) | opc;
            5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12)
                      | (rd << 7) | opc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit legal(input int unsigned fmt, input logic [31:0] imm);
        int si;
        si = $signed(imm);
        if (fmt > 5) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        case (fmt)
            1, 2: return si >= -2048 && si <= 2047;
            3:    return si >= -4096 && si <= 4095 && imm[0] == 1'b0;
            4:    return (imm % 4096) == 0;
            5:    return si >= -(1 << 20) && si < (1 << 20) && imm[0] == 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".we"},    {31'd0, imem_we}, {31'd0, m_we});
        chk({tag, ".err"},   {31'd0, err},     {31'd0, m_err});
        chk({tag, ".count"}, {29'd0, count},   32'(m_count));
        chk({tag, ".full"},  {31'd0, full},    {31'd0, m_count == DEPTH});
        chk({tag, ".addr"},  imem_addr,        m_addr);
        chk({tag, ".wdata"}, imem_wdata,       m_wdata);
    endtask

    // One clock cycle of stimulus, with model update and checks after the edge.
    task automatic cyc(input string tag, input logic st, input logic v, input logic [2:0] fmt,
                       input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic kchk, input logic [31:0] known);
        bit exp_ready, hs, ok;
        start = st; in_valid = v; in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        #1;
        exp_ready = m_run && (m_count < DEPTH) && !st;
        chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        hs = v && exp_ready;
        ok = legal(fmt, imm);
        @(posedge clk);
        #1;
        m_we  = hs && ok;
        m_err = hs && !ok;
        if (st) begin
            m_run   = 1'b1;
            m_count = 0;
        end
        if (m_we) begin
            m_addr  = BASE + 32'(4 * m_count);
            m_wdata = enc(fmt, opc, rd, rs1, rs2, f3, f7, imm);
            m_count++;
        end
        check_outputs(tag);
        if (kchk) begin
            chk({tag, ".known_we"},   {31'd0, imem_we}, 32'd1);
            chk({tag, ".known_word"}, imem_wdata, known);
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input logic st);
        cyc(tag, st, 1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_run = 1'b0; m_count = 0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
        check_outputs(tag);
        chk({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, imm;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        #2;
        do_reset("reset");
        // Valid before start is never accepted.
        cyc("pre_start", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        idle("start0", 1'b1);
        cyc("add",  1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,  1'b1,
            32'h003100B3);
        cyc("addi", 1'b0, 1'b1, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5,  1'b1,
            32'h00510093);
        cyc("lw",   1'b0, 1'b1, 3'd1, 7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd16, 1'b1,
            32'h01012083);
        idle("hold3", 1'b0);
        idle("start1", 1'b1);
        cyc("sw",   1'b0, 1'b1, 3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'd20, 1'b1,
            32'h00112A23);
        cyc("beq",  1'b0, 1'b1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1,
            32'hFE208EE3);
        cyc("jal",  1'b0, 1'b1, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd32, 1'b1,
            32'h020000EF);
        cyc("lui",  1'b0, 1'b1, 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1,
            32'h123450B7);
        // Fifth bundle held while full: must not be accepted.
        cyc("fifth_a", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        cyc("fifth_b", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        // Start with valid asserted: start wins.
        cyc("start_win", 1'b1, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0, 1'b0, 0);
        cyc("restart", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b1,
            32'h003100B3);
        chk("restart.addr0", imem_addr, BASE);
        cyc("illegal", 1'b0, 1'b1, 3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        cyc("after_ill", 1'b0, 1'b1, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1,
            32'h00510093);
        chk("after_ill.addr4", imem_addr, BASE + 32'd4);
`ifdef IMM_RANGE_CHECK_EN
        cyc("addi2048", 1'b0, 1'b1, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 0);
        chk("addi2048.err", {31'd0, err}, 32'd1);
`else
        cyc("addi2048", 1'b0, 1'b1, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1,
            32'h80010093);
`endif
        // Reset in the cycle after a handshake discards the pending write.
        idle("start2", 1'b1);
        cyc("pre_rst", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        in_valid = 1'b1;
        do_reset("mid_rst");
        cyc("post_rst", 1'b0, 1'b1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);
        idle("start3", 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            r = $urandom;
            if (r[0]) imm = $urandom;
            else      imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            cyc("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), imm, 1'b0, 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
